// File: rtl/udl_counter.sv
// ---------------------------------------------------------------------------
// udl_counter
//
// Parameterised synchronous up/down binary counter with parallel load and
// count enable. The count is held in a single register. The terminal-count
// flags are decoded from that register.
//
// Parameters:
//   BITS      counter width in bits (>= 1); count range 0 .. 2^BITS-1
//
// Ports:
//   clk       in   1     rising-edge clock
//   reset_n   in   1     synchronous reset, ACTIVE-HIGH (1 clears Q)
//   enable    in   1     count enable: 1 = step once per clock, 0 = hold
//   up        in   1     direction: 1 = increment, 0 = decrement
//   load      in   1     synchronous parallel load: 1 = Q takes D
//   D         in   BITS  parallel load value
//   Q         out  BITS  current count (registered)
//   max_tick  out  1     1 when Q == 2^BITS-1 (combinational decode of Q)
//   min_tick  out  1     1 when Q == 0 (combinational decode of Q)
//
// Per-edge priority: reset, then load, then count up/down, then hold.
// Counting wraps modulo 2^BITS in both directions.
// ---------------------------------------------------------------------------
module udl_counter #(
    parameter int BITS = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            enable,
    input  logic            up,
    input  logic            load,
    input  logic [BITS-1:0] D,
    output logic [BITS-1:0] Q,
    output logic            max_tick,
    output logic            min_tick
);

    // The reset input is active-high even though its name ends in _n.
    // Reset is sampled only on the clock edge. It is not in the sensitivity list.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments. Every
        // flop then samples values from before the edge, so there
        // are no simulation ordering races.
        if (reset_n) begin
            Q <= '0;
        end else if (load) begin
            Q <= D;
        end else if (enable) begin
            // BITS-wide unsigned add/subtract gives the modulo wrap by
            // itself (all-ones + 1 -> 0, 0 - 1 -> all-ones).
            if (up) begin
                Q <= Q + 1'b1;
            end else begin
                Q <= Q - 1'b1;
            end
        end
    end

    // The flags decode only the registered count, so no input feeds them
    // combinationally.
    assign max_tick = (Q == {BITS{1'b1}});
    assign min_tick = (Q == {BITS{1'b0}});

endmodule

// File: tb/tb_udl_counter.sv
// ---------------------------------------------------------------------------
// tb_udl_counter
//
// Directed self-checking bench for udl_counter with BITS = 5.
// Inputs change 1 ns after each rising edge. Outputs are sampled at the
// same time, after the edge that the previous inputs were set up for.
// ---------------------------------------------------------------------------
module tb_udl_counter;

    localparam int BITS = 5;

    logic            clk;
    logic            reset_n;
    logic            enable;
    logic            up;
    logic            load;
    logic [BITS-1:0] D;
    logic [BITS-1:0] Q;
    logic            max_tick;
    logic            min_tick;

    int checks   = 0;
    int failures = 0;

    udl_counter #(.BITS(BITS)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .up       (up),
        .load     (load),
        .D        (D),
        .Q        (Q),
        .max_tick (max_tick),
        .min_tick (min_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Advance one rising edge. Then settle so that outputs can be sampled
    // and the next inputs can be driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check the count and both flags against the value expected for it.
    task automatic check_q(input string tag, input int exp_q);
        check({tag, ".Q"}, int'(Q), exp_q);
        check({tag, ".max"}, int'(max_tick), (exp_q == 31) ? 1 : 0);
        check({tag, ".min"}, int'(min_tick), (exp_q == 0) ? 1 : 0);
    endtask

    initial begin
        reset_n = 1'b1;
        enable  = 1'b0;
        up      = 1'b0;
        load    = 1'b0;
        D       = '0;

        // Reset state.
        step();
        check_q("reset", 0);
        check("reset.min_explicit", int'(min_tick), 1);

        // Count up 1..15.
        reset_n = 1'b0;
        enable  = 1'b1;
        up      = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            check_q($sformatf("up%0d", i), i);
        end

        // Hold at 15.
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_q("hold15", 15);
        end

        // Count down twice, load 9, then count down to 2.
        up     = 1'b0;
        enable = 1'b1;
        step(); check_q("dn14", 14);
        step(); check_q("dn13", 13);
        load = 1'b1; D = 5'd9;
        step(); check_q("load9", 9);
        load = 1'b0;
        for (int i = 8; i >= 2; i--) begin
            step();
            check_q($sformatf("dn%0d", i), i);
        end

        // Hold load high for two edges, then count down.
        load = 1'b1; D = 5'd7;
        step(); check_q("hload7a", 7);
        step(); check_q("hload7b", 7);
        load = 1'b0;
        for (int i = 6; i >= 2; i--) begin
            step();
            check_q($sformatf("dn_b%0d", i), i);
        end

        // D changes while load is held. Q follows D one edge later.
        load = 1'b1; D = 5'd3;
        step(); check_q("track3", 3);
        D = 5'd4;
        step(); check_q("track4", 4);

        // Load 11 while up is set, then count up.
        D = 5'd11; up = 1'b1;
        step(); check_q("load11a", 11);
        step(); check_q("load11b", 11);
        load = 1'b0;
        step(); check_q("up12", 12);
        step(); check_q("up13", 13);

        // Wrap upward: 31 -> 0.
        load = 1'b1; D = 5'd31;
        step(); check_q("load31", 31);
        load = 1'b0;
        step(); check_q("wrap_up", 0);

        // Wrap downward: 0 -> 31.
        load = 1'b1; D = 5'd0;
        step(); check_q("load0", 0);
        load = 1'b0; up = 1'b0;
        step(); check_q("wrap_dn", 31);

        // Priority: reset beats load, and load beats count.
        load = 1'b1; D = 5'd10;
        step(); check_q("load10", 10);
        reset_n = 1'b1; D = 5'd20;
        step(); check_q("rst_vs_load", 0);
        reset_n = 1'b0; load = 1'b1; enable = 1'b1; up = 1'b1; D = 5'd5;
        step(); check_q("load_vs_cnt", 5);
        enable = 1'b0; load = 1'b0;
        step(); check_q("hold5a", 5);
        step(); check_q("hold5b", 5);

        // Reset while counting.
        enable = 1'b1;
        step(); check_q("up6", 6);
        reset_n = 1'b1;
        step(); check_q("rst_mid", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
